// File: rtl/bramac_pkg.sv
// Shared types and constants for the BrAMAC 2-SA controller.
package bramac_pkg;

  // Control-field offsets counted down from the instruction MSB:
  // [MSB] rsv, [MSB-1] reset, [MSB-2] start, [MSB-3] done, [MSB-4:MSB-5] mode.
  localparam int F_RST   = 2;
  localparam int F_START = 3;
  localparam int F_DONE  = 4;
  localparam int F_MODE  = 6;  // mode occupies inst[DWIDTH-F_MODE +: 2]

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_LD_W1, S_LD_W2, S_PREADD,
    S_INV, S_SUB, S_ASL, S_ACC, S_LD_I2, S_DONE
  } state_e;

  // Dummy-array row map
  localparam logic [2:0] ROW_ZERO = 3'd0;
  localparam logic [2:0] ROW_W1   = 3'd1;
  localparam logic [2:0] ROW_W2   = 3'd2;
  localparam logic [2:0] ROW_W12  = 3'd3;
  localparam logic [2:0] ROW_INV  = 3'd4;
  localparam logic [2:0] ROW_PSUM = 3'd5;
  localparam logic [2:0] ROW_ACC  = 3'd6;

  localparam logic [1:0] WSEL1_INV = 2'd0;
  localparam logic [1:0] WSEL1_SUM = 2'd1;
  localparam logic [1:0] WSEL1_ASL = 2'd2;
  localparam logic       WSEL2_ZERO = 1'b0;
  localparam logic       WSEL2_RAM  = 1'b1;

  // Activation precision selected by the mode field
  function automatic int prec_of(input logic [1:0] mode, input int act_w);
    case (mode)
      2'b01:   return 2;
      2'b10:   return 4;
      2'b11:   return act_w;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/bramac_act_shifter.sv
// Holds both activations and the serial bit index; presents the 2-bit
// activation pair for the current bit as a row selector.
module bramac_act_shifter #(
  parameter int ACT_W = 8,
  parameter int BW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_ld1,
  input  logic             i_ld2,
  input  logic [ACT_W-1:0] i_din,
  input  logic             i_bit_ld,
  input  logic [BW-1:0]    i_bit_val,
  input  logic             i_bit_dec,
  output logic [1:0]       o_act_dec,
  output logic             o_last_bit
);
  logic [ACT_W-1:0] r_in1, r_in2;
  logic [BW-1:0]    r_bit;

  // Activation latches and bit index; soft clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in1 <= '0;
      r_in2 <= '0;
      r_bit <= '0;
    end else if (i_clr) begin
      r_in1 <= '0;
      r_in2 <= '0;
      r_bit <= '0;
    end else begin
      if (i_ld1) r_in1 <= i_din;
      if (i_ld2) r_in2 <= i_din;
      if (i_bit_ld)       r_bit <= i_bit_val;
      else if (i_bit_dec) r_bit <= r_bit - 1'b1;
    end
  end

  assign o_act_dec  = {r_in2[r_bit], r_in1[r_bit]};
  assign o_last_bit = (r_bit == '0);

endmodule

// File: rtl/bramac_sa_fsm_param.sv
// BrAMAC 2-SA controller: sequences the dummy-array ports of an M20K in
// compute mode for a bit-serial two-input MAC with a valid/ready front end.
module bramac_sa_fsm_param
  import bramac_pkg::*;
#(
  parameter int DWIDTH   = 40,
  parameter int ACT_W    = 8,
  parameter int DUMMY_AW = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                comp_en,
  input  logic                inst_valid,
  input  logic [DWIDTH-1:0]   inst,
  output logic                inst_ready,
  output logic                busy,
  output logic                done_o,
  output logic                err_mode,
  output logic                ren_1,
  output logic                ren_2,
  output logic                wen_1,
  output logic                wen_2,
  output logic [DUMMY_AW-1:0] raddr_1,
  output logic [DUMMY_AW-1:0] raddr_2,
  output logic [DUMMY_AW-1:0] waddr_1,
  output logic [DUMMY_AW-1:0] waddr_2,
  output logic [1:0]          wsel_1,
  output logic                wsel_2
);
  localparam int BW = (ACT_W > 2) ? $clog2(ACT_W) : 1;

  state_e     r_state;
  logic [1:0] r_mode;
  logic       r_err;

  logic             w_rst_cmd, w_start, w_done, w_acc, w_go;
  logic [1:0]       w_mode;
  logic [ACT_W-1:0] w_din;
  int               w_prec;
  logic [BW-1:0]    w_bit_val;
  logic             w_ld1, w_ld2, w_bit_ld, w_bit_dec, w_last_bit;
  logic [1:0]       w_act_dec;
  logic             w_unused;

  function automatic logic [DUMMY_AW-1:0] row(input logic [2:0] r);
    return DUMMY_AW'(r);
  endfunction

  assign w_rst_cmd = inst_valid & comp_en & inst[DWIDTH-F_RST];
  assign w_start   = inst[DWIDTH-F_START];
  assign w_done    = inst[DWIDTH-F_DONE];
  assign w_mode    = inst[DWIDTH-F_MODE +: 2];
  assign w_din     = inst[ACT_W-1:0];
  assign w_unused  = ^{inst[DWIDTH-1], inst[DWIDTH-F_MODE-1:ACT_W]};

  assign inst_ready = (r_state inside {S_IDLE, S_LD_W1, S_LD_W2, S_ACC, S_LD_I2, S_DONE});
  assign w_acc      = inst_valid & comp_en & inst_ready;
  // done wins over start when both are set
  assign w_go       = w_acc & w_start & ~w_done;
  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done_o     = (r_state == S_DONE);
  assign err_mode   = r_err;

  assign w_prec    = prec_of(r_mode, ACT_W);
  assign w_bit_val = (r_state == S_SUB) ? BW'(w_prec - 2) : BW'(w_prec - 1);
  assign w_bit_ld  = (r_state == S_PREADD) || (r_state == S_SUB) ||
                     ((r_state == S_LD_I2) && w_acc);
  assign w_bit_dec = (r_state == S_ASL);
  assign w_ld1     = w_acc && ((r_state == S_LD_W1) ||
                               ((r_state == S_ACC) && !w_done && !w_start));
  assign w_ld2     = w_acc && ((r_state == S_LD_W2) || (r_state == S_LD_I2));

  bramac_act_shifter #(.ACT_W(ACT_W), .BW(BW)) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_rst_cmd),
    .i_ld1     (w_ld1),
    .i_ld2     (w_ld2),
    .i_din     (w_din),
    .i_bit_ld  (w_bit_ld),
    .i_bit_val (w_bit_val),
    .i_bit_dec (w_bit_dec),
    .o_act_dec (w_act_dec),
    .o_last_bit(w_last_bit)
  );

  // Sequencer: soft reset from any state, otherwise step the MAC schedule
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= 2'b00;
      r_err   <= 1'b0;
    end else if (w_rst_cmd) begin
      r_state <= S_IDLE;
      r_mode  <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE, S_DONE:
          if (w_go) begin
            if (w_mode == 2'b00) r_err <= 1'b1;
            else begin
              r_mode  <= w_mode;
              r_state <= S_INIT;
            end
          end
        S_INIT:   r_state <= S_LD_W1;
        S_LD_W1:  if (w_acc) r_state <= S_LD_W2;
        S_LD_W2:  if (w_acc) r_state <= S_PREADD;
        S_PREADD: r_state <= S_INV;
        S_INV:    r_state <= S_SUB;
        S_SUB:    r_state <= S_ASL;
        S_ASL:    if (w_last_bit) r_state <= S_ACC;
        S_ACC:
          if (w_acc) begin
            if (w_done) r_state <= S_DONE;
            else if (w_start) begin
              // weight reload keeps ACC; a bad mode flags but keeps old precision
              if (w_mode == 2'b00) r_err <= 1'b1;
              else r_mode <= w_mode;
              r_state <= S_LD_W1;
            end else r_state <= S_LD_I2;
          end
        S_LD_I2:  if (w_acc) r_state <= S_INV;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Port decode; every field defaults to 0 so idle lanes never float
  always_comb begin
    ren_1   = 1'b0;  ren_2   = 1'b0;
    wen_1   = 1'b0;  wen_2   = 1'b0;
    raddr_1 = '0;    raddr_2 = '0;
    waddr_1 = '0;    waddr_2 = '0;
    wsel_1  = WSEL1_INV;
    wsel_2  = WSEL2_ZERO;
    case (r_state)
      S_INIT: begin
        wen_2 = 1'b1; waddr_2 = row(ROW_ACC); wsel_2 = WSEL2_ZERO;
      end
      S_LD_W1: begin
        wen_2 = w_acc; waddr_2 = row(ROW_W1); wsel_2 = WSEL2_RAM;
      end
      S_LD_W2: begin
        wen_2 = w_acc; waddr_2 = row(ROW_W2); wsel_2 = WSEL2_RAM;
      end
      S_PREADD: begin
        ren_1 = 1'b1; raddr_1 = row(ROW_W1);
        ren_2 = 1'b1; raddr_2 = row(ROW_W2);
        wen_1 = 1'b1; waddr_1 = row(ROW_W12);  wsel_1 = WSEL1_SUM;
        wen_2 = 1'b1; waddr_2 = row(ROW_PSUM); wsel_2 = WSEL2_ZERO;
      end
      S_INV: begin
        ren_1 = 1'b1; raddr_1 = DUMMY_AW'(w_act_dec);
        wen_1 = 1'b1; waddr_1 = row(ROW_INV); wsel_1 = WSEL1_INV;
      end
      S_SUB: begin
        ren_1 = 1'b1; raddr_1 = row(ROW_INV);
        ren_2 = 1'b1; raddr_2 = row(ROW_PSUM);
        wen_1 = 1'b1; waddr_1 = row(ROW_PSUM); wsel_1 = WSEL1_SUM;
      end
      S_ASL: begin
        ren_1 = 1'b1; raddr_1 = DUMMY_AW'(w_act_dec);
        ren_2 = 1'b1; raddr_2 = row(ROW_PSUM);
        wen_1 = 1'b1; waddr_1 = row(ROW_PSUM); wsel_1 = WSEL1_ASL;
      end
      S_ACC: begin
        ren_1 = 1'b1;  raddr_1 = row(ROW_PSUM);
        ren_2 = 1'b1;  raddr_2 = row(ROW_ACC);
        wen_1 = w_acc; waddr_1 = row(ROW_ACC); wsel_1 = WSEL1_SUM;
      end
      S_LD_I2: begin
        wen_2 = w_acc; waddr_2 = row(ROW_PSUM); wsel_2 = WSEL2_ZERO;
      end
      S_DONE: begin
        ren_2 = 1'b1; raddr_2 = row(ROW_ACC);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bramac_sa_fsm_param.sv
// Bench for bramac_sa_fsm_param: step-indexed MAC reference model compared
// every cycle, plus hand-computed checks on schedules and counts.
module tb_bramac_sa_fsm_param;
  logic        clk = 1'b0, rst_n = 1'b0, comp_en = 1'b1, inst_valid = 1'b0;
  logic [39:0] inst = '0;
  logic        inst_ready, busy, done_o, err_mode, ren_1, ren_2, wen_1, wen_2, wsel_2;
  logic [2:0]  raddr_1, raddr_2, waddr_1, waddr_2;
  logic [1:0]  wsel_1;

  int tests = 0, fails = 0, cyc = 0;
  int asl_q[$], inv_q[$];
  int acc_wr = 0, init_wr = 0, ldi2_n = 0, pre_cyc = 0, acc_cyc = 0;

  bramac_sa_fsm_param #(.DWIDTH(40), .ACT_W(8), .DUMMY_AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .comp_en(comp_en), .inst_valid(inst_valid), .inst(inst),
    .inst_ready(inst_ready), .busy(busy), .done_o(done_o), .err_mode(err_mode),
    .ren_1(ren_1), .ren_2(ren_2), .wen_1(wen_1), .wen_2(wen_2),
    .raddr_1(raddr_1), .raddr_2(raddr_2), .waddr_1(waddr_1), .waddr_2(waddr_2),
    .wsel_1(wsel_1), .wsel_2(wsel_2));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_INIT = 1, M_LDW1 = 2, M_LDW2 = 3,
                 M_PRE = 4, M_MAC = 5, M_LDI2 = 6, M_DONE = 7;
  int ph = M_IDLE, st = 0, P = 0;
  logic [7:0] a1 = '0, a2 = '0;
  logic m_err = 1'b0;

  function automatic int prec(input logic [1:0] m);
    case (m) 2'd1: return 2; 2'd2: return 4; 2'd3: return 8; default: return 0; endcase
  endfunction

  // activation pair of bit b selects rows 0..3
  function automatic logic [2:0] act(input int b);
    return 3'((a2 >> b) & 1) * 3'd2 + 3'((a1 >> b) & 1);
  endfunction

  always @(negedge clk) begin : model_cmp
    logic rdy, acc, rc, e_busy;
    logic e_ren1, e_ren2, e_wen1, e_wen2, e_ws2;
    logic [2:0] e_ra1, e_ra2, e_wa1, e_wa2;
    logic [1:0] e_ws1;
    logic [22:0] ev, gv;
    cyc++;
    if (!rst_n) begin ph = M_IDLE; st = 0; P = 0; a1 = 0; a2 = 0; m_err = 0; end
    rdy = (ph == M_IDLE) || (ph == M_LDW1) || (ph == M_LDW2) || (ph == M_LDI2) ||
          (ph == M_DONE) || (ph == M_MAC && st == P + 1);
    acc = inst_valid && comp_en && rdy;
    rc  = inst_valid && comp_en && inst[38];
    e_busy = (ph != M_IDLE) && (ph != M_DONE);
    e_ren1 = 0; e_ren2 = 0; e_wen1 = 0; e_wen2 = 0; e_ws2 = 0;
    e_ra1 = 0; e_ra2 = 0; e_wa1 = 0; e_wa2 = 0; e_ws1 = 0;
    case (ph)
      M_INIT: begin e_wen2 = 1; e_wa2 = 6; end
      M_LDW1: begin e_wen2 = acc; e_wa2 = 1; e_ws2 = 1; end
      M_LDW2: begin e_wen2 = acc; e_wa2 = 2; e_ws2 = 1; end
      M_PRE:  begin e_ren1 = 1; e_ra1 = 1; e_ren2 = 1; e_ra2 = 2;
                    e_wen1 = 1; e_wa1 = 3; e_ws1 = 1; e_wen2 = 1; e_wa2 = 5; end
      M_MAC:
        if (st == 0)      begin e_ren1 = 1; e_ra1 = act(P - 1); e_wen1 = 1; e_wa1 = 4; e_ws1 = 0; end
        else if (st == 1) begin e_ren1 = 1; e_ra1 = 4; e_ren2 = 1; e_ra2 = 5;
                                e_wen1 = 1; e_wa1 = 5; e_ws1 = 1; end
        else if (st <= P) begin e_ren1 = 1; e_ra1 = act(P - st); e_ren2 = 1; e_ra2 = 5;
                                e_wen1 = 1; e_wa1 = 5; e_ws1 = 2; end
        else              begin e_ren1 = 1; e_ra1 = 5; e_ren2 = 1; e_ra2 = 6;
                                e_wen1 = acc; e_wa1 = 6; e_ws1 = 1; end
      M_LDI2: begin e_wen2 = acc; e_wa2 = 5; end
      M_DONE: begin e_ren2 = 1; e_ra2 = 6; end
      default: ;
    endcase
    ev = {rdy, e_busy, ph == M_DONE, m_err, e_ren1, e_ren2, e_wen1, e_wen2,
          e_ra1, e_ra2, e_wa1, e_wa2, e_ws1, e_ws2};
    gv = {inst_ready, busy, done_o, err_mode, ren_1, ren_2, wen_1, wen_2,
          raddr_1, raddr_2, waddr_1, waddr_2, wsel_1, wsel_2};
    tests++;
    if (gv !== ev) begin
      fails++;
      $display("FAIL cycle_outputs cyc=%0d got=%h exp=%h", cyc, gv, ev);
    end
    // event monitor for the literal checks
    if (wen_1 && wsel_1 == 2) asl_q.push_back(int'(raddr_1));
    if (wen_1 && wsel_1 == 0) inv_q.push_back(int'(raddr_1));
    if (wen_1 && waddr_1 == 3) pre_cyc = cyc;
    if (wen_1 && waddr_1 == 6) begin acc_wr++; acc_cyc = cyc; end
    if (wen_2 && waddr_2 == 6) init_wr++;
    if (wen_2 && waddr_2 == 5 && !wen_1) ldi2_n++;
    // advance model to the state after the coming edge
    if (rst_n) begin
      if (rc) begin ph = M_IDLE; st = 0; a1 = 0; a2 = 0; end
      else case (ph)
        M_IDLE, M_DONE:
          if (acc && inst[37] && !inst[36]) begin
            if (inst[35:34] == 0) m_err = 1;
            else begin P = prec(inst[35:34]); ph = M_INIT; end
          end
        M_INIT: ph = M_LDW1;
        M_LDW1: if (acc) begin a1 = inst[7:0]; ph = M_LDW2; end
        M_LDW2: if (acc) begin a2 = inst[7:0]; ph = M_PRE; end
        M_PRE:  begin ph = M_MAC; st = 0; end
        M_MAC:
          if (st < P + 1) st++;
          else if (acc) begin
            if (inst[36]) ph = M_DONE;
            else if (inst[37]) begin
              if (inst[35:34] == 0) m_err = 1; else P = prec(inst[35:34]);
              ph = M_LDW1;
            end else begin a1 = inst[7:0]; ph = M_LDI2; end
          end
        M_LDI2: if (acc) begin a2 = inst[7:0]; ph = M_MAC; st = 0; end
        default: ;
      endcase
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [39:0] mk(input logic r, input logic s, input logic d,
                                     input logic [1:0] m, input logic [7:0] din);
    return {1'b0, r, s, d, m, 26'd0, din};
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic clr_mon();
    asl_q.delete(); inv_q.delete();
    acc_wr = 0; init_wr = 0; ldi2_n = 0;
  endtask

  // present one instruction and hold it until accepted
  task automatic send(input logic [39:0] v);
    int n;
    n = 0;
    inst = v; inst_valid = 1'b1;
    @(negedge clk);
    while (!(inst_ready && comp_en) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin tests++; fails++; $display("FAIL send_timeout inst=%h", v); end
    sync();
    inst_valid = 1'b0;
  endtask

  // 1: ASL cycle, 2: SUB cycle, else: ACC state
  task automatic wait_for(input int what, input string nm);
    int n; bit hit;
    n = 0; hit = 0;
    while (!hit && n < 200) begin
      @(negedge clk); n++;
      case (what)
        1:       hit = wen_1 && wsel_1 == 2;
        2:       hit = wen_1 && waddr_1 == 5 && wsel_1 == 1 && raddr_1 == 4;
        default: hit = ren_1 && raddr_1 == 5 && ren_2 && raddr_2 == 6 && busy;
      endcase
    end
    if (!hit) begin tests++; fails++; $display("FAIL wait_%s timeout got=0 exp=1", nm); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int exp_asl[7];
    exp_asl = '{2, 2, 2, 2, 2, 2, 3};
    repeat (3) @(negedge clk);
    chk("reset_ready", int'(inst_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_err", int'(err_mode), 0);
    sync(); rst_n = 1'b1;

    // T1: P=8, in1=0x81, in2=0x7F, done at first ACC
    clr_mon();
    send(mk(0, 1, 0, 2'd3, 8'h00));
    send(mk(0, 0, 0, 2'd0, 8'h81));
    send(mk(0, 0, 0, 2'd0, 8'h7F));
    send(mk(0, 0, 1, 2'd0, 8'h00));
    @(negedge clk);
    chk("t1_done", int'(done_o), 1);
    chk("t1_preadd_to_acc", acc_cyc - pre_cyc + 1, 11);
    chk("t1_asl_len", asl_q.size(), 7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("t1_asl_raddr%0d", i), (i < asl_q.size()) ? asl_q[i] : -1, exp_asl[i]);
    chk("t1_inv_len", inv_q.size(), 1);
    chk("t1_inv_raddr", (inv_q.size() > 0) ? inv_q[0] : -1, 1);
    chk("t1_init_wr", init_wr, 1);
    sync(); send(mk(1, 0, 0, 2'd0, 8'h00));

    // T2: P=2, three MACs back to back
    clr_mon();
    send(mk(0, 1, 0, 2'd1, 8'h00));
    send(mk(0, 0, 0, 2'd0, 8'h02));
    send(mk(0, 0, 0, 2'd0, 8'h01));
    send(mk(0, 0, 0, 2'd0, 8'h03));
    send(mk(0, 0, 0, 2'd0, 8'h01));
    send(mk(0, 0, 0, 2'd0, 8'h01));
    send(mk(0, 0, 0, 2'd0, 8'h02));
    send(mk(0, 0, 1, 2'd0, 8'h00));
    @(negedge clk);
    chk("t2_acc_writes", acc_wr, 3);
    chk("t2_ldi2_loops", ldi2_n, 2);
    chk("t2_inv_count", inv_q.size(), 3);
    chk("t2_asl_count", asl_q.size(), 3);
    sync(); send(mk(1, 0, 0, 2'd0, 8'h00));

    // T3: valid low in LD_W2 and in ACC, then comp_en low in ACC
    clr_mon();
    send(mk(0, 1, 0, 2'd2, 8'h00));
    send(mk(0, 0, 0, 2'd0, 8'h5A));
    repeat (5) @(negedge clk);
    chk("t3_ldw2_hold", int'({busy, inst_ready, wen_2}), 6);
    sync();
    send(mk(0, 0, 0, 2'd0, 8'hC3));
    wait_for(3, "t3_acc");
    repeat (5) @(negedge clk);
    sync();
    inst = mk(0, 0, 1, 2'd0, 8'h00); inst_valid = 1'b1; comp_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_acc_hold_writes", acc_wr, 0);
    chk("t3_acc_hold_busy", int'(busy), 1);
    sync(); comp_en = 1'b1;
    send(mk(0, 0, 1, 2'd0, 8'h00));
    @(negedge clk);
    chk("t3_acc_writes", acc_wr, 1);
    chk("t3_done", int'(done_o), 1);
    sync(); send(mk(1, 0, 0, 2'd0, 8'h00));

    // T4: illegal mode, then a normal run with the error still flagged
    send(mk(0, 1, 0, 2'd0, 8'h00));
    @(negedge clk);
    chk("t4_err_set", int'(err_mode), 1);
    chk("t4_stay_idle", int'(busy), 0);
    sync();
    send(mk(0, 1, 0, 2'd2, 8'h00));
    send(mk(0, 0, 0, 2'd0, 8'h09));
    send(mk(0, 0, 0, 2'd0, 8'h06));
    send(mk(0, 0, 1, 2'd0, 8'h00));
    @(negedge clk);
    chk("t4_done", int'(done_o), 1);
    chk("t4_err_kept", int'(err_mode), 1);
    sync(); send(mk(1, 0, 0, 2'd0, 8'h00));
    @(negedge clk);
    chk("t4_err_after_soft_rst", int'(err_mode), 1);
    sync();

    // T5: soft reset inside ASL, then async reset inside SUB
    send(mk(0, 1, 0, 2'd3, 8'h00));
    send(mk(0, 0, 0, 2'd0, 8'h33));
    send(mk(0, 0, 0, 2'd0, 8'hCC));
    wait_for(1, "t5_asl");
    sync();
    inst = mk(1, 0, 0, 2'd0, 8'h00); inst_valid = 1'b1;
    @(negedge clk);
    sync(); inst_valid = 1'b0;
    @(negedge clk);
    chk("t5_soft_rst_idle", int'({busy, ren_1, ren_2, wen_1, wen_2}), 0);
    chk("t5_soft_rst_ready", int'(inst_ready), 1);
    sync();
    send(mk(0, 1, 0, 2'd3, 8'h00));
    send(mk(0, 0, 0, 2'd0, 8'hF0));
    send(mk(0, 0, 0, 2'd0, 8'h0F));
    wait_for(2, "t5_sub");
    #2 rst_n = 1'b0;
    #1 chk("t5_async_rst", int'({busy, ren_1, ren_2, wen_1, wen_2, err_mode, done_o}), 0);
    @(negedge clk);
    sync(); rst_n = 1'b1;

    // T6: start at ACC reloads weights and keeps ACC
    send(mk(0, 1, 0, 2'd1, 8'h00));
    send(mk(0, 0, 0, 2'd0, 8'h03));
    send(mk(0, 0, 0, 2'd0, 8'h01));
    wait_for(3, "t6_acc");
    sync();
    clr_mon();
    send(mk(0, 1, 0, 2'd1, 8'h00));
    @(negedge clk);
    chk("t6_in_ldw1", int'({inst_ready, busy}), 3);
    sync();
    send(mk(0, 0, 0, 2'd0, 8'h02));
    send(mk(0, 0, 0, 2'd0, 8'h02));
    send(mk(0, 0, 1, 2'd0, 8'h00));
    @(negedge clk);
    chk("t6_no_acc_reinit", init_wr, 0);
    chk("t6_acc_writes", acc_wr, 2);
    chk("t6_done", int'(done_o), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
